// File: rtl/rv32imf_pkg.sv
// rtl/rv32imf_pkg.sv - shared constants and helpers for the RV32IMF register file
package rv32imf_pkg;

    localparam int REG_ZERO = 0;

    // The bank select is always the address MSB: 0 = integer, 1 = FP.
    function automatic int bank_bit(input int addr_width);
        return addr_width - 1;
    endfunction

    function automatic int pend_cnt_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/rv32imf_regfile_scoreboard.sv
// rtl/rv32imf_regfile_scoreboard.sv - pending-write scoreboard with bounded reservation count
module rv32imf_regfile_scoreboard
    import rv32imf_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int HAS_FP      = 0,
    parameter int NUM_RD      = 3,
    parameter int BYPASS      = 1,
    parameter int MAX_PENDING = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]        raddr,
    output logic [NUM_RD-1:0]                        rbusy,
    input  logic [ADDR_WIDTH-1:0]                    waddr_a,
    input  logic                                     we_a,
    input  logic [ADDR_WIDTH-1:0]                    waddr_b,
    input  logic                                     we_b,
    input  logic                                     rsv_valid,
    input  logic [ADDR_WIDTH-1:0]                    rsv_addr,
    output logic                                     rsv_ready,
    input  logic                                     flush,
    output logic [pend_cnt_width(MAX_PENDING)-1:0]   pend_cnt
);

    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam int BB    = bank_bit(ADDR_WIDTH);
    localparam int CW    = pend_cnt_width(MAX_PENDING);

    function automatic logic is_null(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(REG_ZERO)) || (a[BB] && (HAS_FP == 0));
    endfunction

    logic [NREGS-1:0] pending, pending_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             clr_a, clr_b, accept;

    assign rsv_ready = !pending[rsv_addr]
                     && (is_null(rsv_addr) || (cnt < CW'(MAX_PENDING)))
                     && !flush;
    assign pend_cnt  = cnt;

    always_comb begin
        clr_a     = we_a && pending[waddr_a];
        // Both ports hitting the same pending register retire it only once.
        clr_b     = we_b && pending[waddr_b] && !(clr_a && (waddr_a == waddr_b));
        accept    = rsv_valid && rsv_ready && !is_null(rsv_addr);
        pending_n = pending;
        cnt_n     = cnt;
        if (flush) begin
            pending_n = '0;
            cnt_n     = '0;
        end else begin
            if (we_a)   pending_n[waddr_a]  = 1'b0;
            if (we_b)   pending_n[waddr_b]  = 1'b0;
            if (accept) pending_n[rsv_addr] = 1'b1;
            cnt_n = cnt + CW'(accept) - CW'(clr_a) - CW'(clr_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            cnt     <= '0;
        end else begin
            pending <= pending_n;
            cnt     <= cnt_n;
        end
    end

    always_comb begin
        rbusy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rbusy[k] = pending[raddr[k]]
                     && !((BYPASS != 0) && ((we_a && (waddr_a == raddr[k]))
                                         || (we_b && (waddr_b == raddr[k]))));
        end
    end

    cnt_matches_pending: assert property (@(posedge clk) disable iff (!rst_n)
        ($countones(pending) == int'(cnt)) && (int'(cnt) <= MAX_PENDING));

endmodule

// File: rtl/rv32imf_regfile_sb.sv
// rtl/rv32imf_regfile_sb.sv - integer/FP register file with write bypass and scoreboard
module rv32imf_regfile_sb
    import rv32imf_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int FPU         = 0,
    parameter int ZFINX       = 0,
    parameter int NUM_RD      = 3,
    parameter int BYPASS      = 1,
    parameter int MAX_PENDING = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]        raddr_i,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]        rdata_o,
    output logic [NUM_RD-1:0]                        rbusy_o,
    input  logic [ADDR_WIDTH-1:0]                    waddr_a_i,
    input  logic [DATA_WIDTH-1:0]                    wdata_a_i,
    input  logic                                     we_a_i,
    input  logic [ADDR_WIDTH-1:0]                    waddr_b_i,
    input  logic [DATA_WIDTH-1:0]                    wdata_b_i,
    input  logic                                     we_b_i,
    input  logic                                     rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]                    rsv_addr_i,
    output logic                                     rsv_ready_o,
    input  logic                                     flush_i,
    output logic [pend_cnt_width(MAX_PENDING)-1:0]   pend_cnt_o
);

    localparam int NREGS  = 1 << ADDR_WIDTH;
    localparam int BB     = bank_bit(ADDR_WIDTH);
    localparam int HAS_FP = ((FPU != 0) && (ZFINX == 0)) ? 1 : 0;

    function automatic logic is_null(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(REG_ZERO)) || (a[BB] && (HAS_FP == 0));
    endfunction

    logic [DATA_WIDTH-1:0] regs [NREGS];

    // Port B is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (we_a_i && !is_null(waddr_a_i)) regs[waddr_a_i] <= wdata_a_i;
            if (we_b_i && !is_null(waddr_b_i)) regs[waddr_b_i] <= wdata_b_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!rst_n || is_null(raddr_i[k])) begin
                rdata_o[k] = '0;
            end else if ((BYPASS != 0) && we_b_i && (waddr_b_i == raddr_i[k])) begin
                rdata_o[k] = wdata_b_i;
            end else if ((BYPASS != 0) && we_a_i && (waddr_a_i == raddr_i[k])) begin
                rdata_o[k] = wdata_a_i;
            end else begin
                rdata_o[k] = regs[raddr_i[k]];
            end
        end
    end

    rv32imf_regfile_scoreboard #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .HAS_FP      (HAS_FP),
        .NUM_RD      (NUM_RD),
        .BYPASS      (BYPASS),
        .MAX_PENDING (MAX_PENDING)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr     (raddr_i),
        .rbusy     (rbusy_o),
        .waddr_a   (waddr_a_i),
        .we_a      (we_a_i),
        .waddr_b   (waddr_b_i),
        .we_b      (we_b_i),
        .rsv_valid (rsv_valid_i),
        .rsv_addr  (rsv_addr_i),
        .rsv_ready (rsv_ready_o),
        .flush     (flush_i),
        .pend_cnt  (pend_cnt_o)
    );

endmodule

// File: tb/tb_rv32imf_regfile_sb.sv
// tb/tb_rv32imf_regfile_sb.sv - randomized and directed bench for rv32imf_regfile_sb
module tb_rv32imf_regfile_sb;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [2:0][5:0]   raddr;
    logic [2:0][31:0]  rdata, rdata_nb, rdata_nf;
    logic [2:0]        rbusy, rbusy_nb, rbusy_nf;
    logic [5:0]        waddr_a, waddr_b, rsv_addr;
    logic [31:0]       wdata_a, wdata_b;
    logic              we_a, we_b, rsv_valid, flush;
    logic              rsv_ready, rsv_ready_nb, rsv_ready_nf;
    logic [2:0]        pend_cnt, pend_cnt_nb, pend_cnt_nf;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_regs [64];
    bit          m_pend [64];

    always #5 clk = ~clk;

    rv32imf_regfile_sb #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(1), .ZFINX(0),
                         .NUM_RD(3), .BYPASS(1), .MAX_PENDING(4)) dut (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready),
        .flush_i(flush), .pend_cnt_o(pend_cnt));

    rv32imf_regfile_sb #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(1), .ZFINX(0),
                         .NUM_RD(3), .BYPASS(0), .MAX_PENDING(4)) dut_nb (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_nb), .rbusy_o(rbusy_nb),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready_nb),
        .flush_i(flush), .pend_cnt_o(pend_cnt_nb));

    rv32imf_regfile_sb #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .FPU(1), .ZFINX(1),
                         .NUM_RD(3), .BYPASS(1), .MAX_PENDING(4)) dut_nf (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_nf), .rbusy_o(rbusy_nf),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready_nf),
        .flush_i(flush), .pend_cnt_o(pend_cnt_nf));

    // Reference model for the FP-enabled, bypassing, MAX_PENDING=4 instance.
    function automatic bit m_null(input int a);
        return a == 0;
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < 64; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (m_null(a)) return 32'h0;
        if (we_b && int'(waddr_b) == a) return wdata_b;
        if (we_a && int'(waddr_a) == a) return wdata_a;
        return m_regs[a];
    endfunction

    function automatic bit m_busy(input int a);
        if ((we_a && int'(waddr_a) == a) || (we_b && int'(waddr_b) == a)) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic bit m_ready();
        int a = int'(rsv_addr);
        return !m_pend[a] && (m_null(a) || m_cnt() < 4) && !flush;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_regs[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic m_edge();
        bit acc;
        acc = rsv_valid && m_ready() && !m_null(int'(rsv_addr));
        if (we_a && !m_null(int'(waddr_a))) begin
            m_regs[waddr_a] = wdata_a;
            m_pend[waddr_a] = 1'b0;
        end
        if (we_b && !m_null(int'(waddr_b))) begin
            m_regs[waddr_b] = wdata_b;
            m_pend[waddr_b] = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < 64; i++) m_pend[i] = 1'b0;
        end else if (acc) begin
            m_pend[rsv_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        we_a = 0; we_b = 0; rsv_valid = 0; flush = 0;
        waddr_a = 0; waddr_b = 0; wdata_a = 0; wdata_b = 0; rsv_addr = 0;
    endtask

    task automatic test_reset();
        idle();
        raddr = '0;
        rst_n = 0;
        m_reset();
        #1;
        for (int a = 0; a < 64; a++) begin
            raddr[0] = 6'(a); raddr[1] = 6'(63 - a); raddr[2] = 6'(a ^ 1);
            #1;
            checks++;
            if (rdata !== '0) begin
                failures++;
                $display("FAIL reset_rdata addr=%0d: got %h expected 0", a, rdata);
            end
        end
        checks++;
        if (rsv_ready !== 1'b1 || pend_cnt !== 3'd0 || rbusy !== 3'b000) begin
            failures++;
            $display("FAIL reset_status: ready=%b cnt=%0d busy=%b expected 1/0/000",
                     rsv_ready, pend_cnt, rbusy);
        end
        flush = 1; #1;
        checks++;
        if (rsv_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_flush: got %b expected 0", rsv_ready);
        end
        flush = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if (rsv_ready !== 1'b1 || pend_cnt !== 3'd0) begin
            failures++;
            $display("FAIL after_reset: ready=%b cnt=%0d expected 1/0", rsv_ready, pend_cnt);
        end
    endtask

    task automatic test_bypass();
        we_a = 1; waddr_a = 5; wdata_a = 32'h11;
        we_b = 1; waddr_b = 5; wdata_b = 32'h22;
        raddr[0] = 5;
        #1;
        checks++;
        if (rdata[0] !== 32'h22) begin
            failures++;
            $display("FAIL bypass_same_cycle: got %h expected 00000022", rdata[0]);
        end
        checks++;
        if (rdata_nb[0] !== 32'h0) begin
            failures++;
            $display("FAIL nobypass_same_cycle: got %h expected 00000000", rdata_nb[0]);
        end
        tick(); idle(); #1;
        checks++;
        if (rdata_nb[0] !== 32'h22 || rdata[0] !== 32'h22) begin
            failures++;
            $display("FAIL b_wins_next_cycle: got %h/%h expected 00000022", rdata[0], rdata_nb[0]);
        end
    endtask

    task automatic test_limit();
        int lst[4] = '{3, 4, 7, 9};
        foreach (lst[i]) begin
            rsv_valid = 1; rsv_addr = 6'(lst[i]); #1;
            checks++;
            if (rsv_ready !== 1'b1) begin
                failures++;
                $display("FAIL reserve_x%0d: ready got %b expected 1", lst[i], rsv_ready);
            end
            tick();
        end
        rsv_addr = 10; #1;
        checks++;
        if (rsv_ready !== 1'b0 || pend_cnt !== 3'd4) begin
            failures++;
            $display("FAIL full_x10: ready=%b cnt=%0d expected 0/4", rsv_ready, pend_cnt);
        end
        we_b = 1; waddr_b = 4; wdata_b = 32'h44; #1;
        checks++;
        if (rsv_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_during_clear: ready got %b expected 0", rsv_ready);
        end
        tick(); we_b = 0; #1;
        checks++;
        if (pend_cnt !== 3'd3 || rsv_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_clear_x4: cnt=%0d ready=%b expected 3/1", pend_cnt, rsv_ready);
        end
        tick(); rsv_valid = 0; raddr[0] = 10; raddr[1] = 4; #1;
        checks++;
        if (pend_cnt !== 3'd4 || rbusy[1:0] !== 2'b01) begin
            failures++;
            $display("FAIL x10_accepted: cnt=%0d busy=%b expected 4/01", pend_cnt, rbusy[1:0]);
        end
    endtask

    task automatic test_dual_clear();
        we_a = 1; waddr_a = 3; wdata_a = 32'h33;
        we_b = 1; waddr_b = 7; wdata_b = 32'h77;
        raddr[0] = 3; raddr[1] = 7; #1;
        checks++;
        if (rbusy[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL dual_clear_bypass_busy: got %b expected 00", rbusy[1:0]);
        end
        tick(); idle(); #1;
        checks++;
        if (pend_cnt !== 3'd2 || rbusy[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL dual_clear: cnt=%0d busy=%b expected 2/00", pend_cnt, rbusy[1:0]);
        end
    endtask

    task automatic test_flush();
        rsv_valid = 1; rsv_addr = 11; tick(); idle(); #1;
        checks++;
        if (pend_cnt !== 3'd3) begin
            failures++;
            $display("FAIL pre_flush_cnt: got %0d expected 3", pend_cnt);
        end
        flush = 1; rsv_valid = 1; rsv_addr = 8; #1;
        checks++;
        if (rsv_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready: got %b expected 0", rsv_ready);
        end
        tick(); idle(); raddr[0] = 8; raddr[1] = 9; raddr[2] = 10; #1;
        checks++;
        if (pend_cnt !== 3'd0 || rbusy !== 3'b000) begin
            failures++;
            $display("FAIL flush_result: cnt=%0d busy=%b expected 0/000", pend_cnt, rbusy);
        end
        rsv_valid = 1; rsv_addr = 1; tick();
        rsv_addr = 0; we_a = 1; waddr_a = 0; wdata_a = 32'hdead;
        we_b = 1; waddr_b = 0; wdata_b = 32'hbeef; raddr[0] = 0; #1;
        checks++;
        if (rsv_ready !== 1'b1 || rdata[0] !== 32'h0) begin
            failures++;
            $display("FAIL x0_request: ready=%b data=%h expected 1/0", rsv_ready, rdata[0]);
        end
        tick(); idle(); #1;
        checks++;
        if (pend_cnt !== 3'd1 || rdata[0] !== 32'h0 || rbusy[0] !== 1'b0) begin
            failures++;
            $display("FAIL x0_after: cnt=%0d data=%h busy=%b expected 1/0/0",
                     pend_cnt, rdata[0], rbusy[0]);
        end
    endtask

    task automatic test_same_cycle();
        rsv_valid = 1; rsv_addr = 6; we_b = 1; waddr_b = 6; wdata_b = 32'h66; #1;
        checks++;
        if (rsv_ready !== 1'b1) begin
            failures++;
            $display("FAIL rsv_write_x6_ready: got %b expected 1", rsv_ready);
        end
        tick(); idle(); raddr[0] = 6; #1;
        checks++;
        if (pend_cnt !== 3'd2 || rbusy[0] !== 1'b1 || rdata[0] !== 32'h66) begin
            failures++;
            $display("FAIL rsv_write_x6: cnt=%0d busy=%b data=%h expected 2/1/66",
                     pend_cnt, rbusy[0], rdata[0]);
        end
        rsv_valid = 1; rsv_addr = 6; #1;
        checks++;
        if (rsv_ready !== 1'b0) begin
            failures++;
            $display("FAIL rerequest_x6: ready got %b expected 0", rsv_ready);
        end
        tick(); idle();
    endtask

    task automatic test_nofp();
        we_a = 1; waddr_a = 35; wdata_a = 32'habc; tick(); idle(); raddr[0] = 35; #1;
        checks++;
        if (rdata[0] !== 32'habc || rdata_nf[0] !== 32'h0) begin
            failures++;
            $display("FAIL fp_bank: fpu=%h zfinx=%h expected 00000abc/0", rdata[0], rdata_nf[0]);
        end
    endtask

    task automatic test_reset_mid();
        rsv_valid = 1; rsv_addr = 12; tick(); idle(); raddr[0] = 6;
        #2; rst_n = 0; #1;
        checks++;
        if (pend_cnt !== 3'd0 || rdata[0] !== 32'h0 || rbusy !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset: cnt=%0d data=%h busy=%b expected 0/0/000",
                     pend_cnt, rdata[0], rbusy);
        end
        m_reset();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        we_a = 1; waddr_a = 13; wdata_a = 32'h1313; tick(); idle(); raddr[0] = 13; #1;
        checks++;
        if (rdata[0] !== 32'h1313 || pend_cnt !== 3'd0) begin
            failures++;
            $display("FAIL write_after_reset: data=%h cnt=%0d expected 1313/0", rdata[0], pend_cnt);
        end
    endtask

    function automatic logic [5:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r == 0) return 6'd0;
        if (r < 8) return 6'(r);
        return 6'(32 + $urandom_range(0, 2));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            we_a = ($urandom_range(0, 1) == 1);  waddr_a = rand_addr(); wdata_a = $urandom;
            we_b = ($urandom_range(0, 4) < 2);   waddr_b = rand_addr(); wdata_b = $urandom;
            rsv_valid = ($urandom_range(0, 4) < 3); rsv_addr = rand_addr();
            flush = ($urandom_range(0, 19) == 0);
            for (int k = 0; k < 3; k++) raddr[k] = rand_addr();
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rdata[k] !== m_read(int'(raddr[k])) || rbusy[k] !== m_busy(int'(raddr[k]))) begin
                    failures++;
                    $display("FAIL rand_read n=%0d port=%0d addr=%0d: data=%h busy=%b expected %h/%b",
                             n, k, raddr[k], rdata[k], rbusy[k],
                             m_read(int'(raddr[k])), m_busy(int'(raddr[k])));
                end
            end
            checks++;
            if (rsv_ready !== m_ready() || int'(pend_cnt) != m_cnt()) begin
                failures++;
                $display("FAIL rand_sb n=%0d: ready=%b cnt=%0d expected %b/%0d",
                         n, rsv_ready, pend_cnt, m_ready(), m_cnt());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_limit();
        test_dual_clear();
        test_flush();
        test_same_cycle();
        test_nofp();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32imf_regfile_sb.md
RV32IMF_REGFILE_SB -- requirements
Module: rv32imf_regfile_sb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6: register address width; MSB selects the bank (0 = integer, 1 = FP).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register width.
REQ-003 SHALL have parameter FPU, default 0: 1 instantiates the FP bank.
REQ-004 SHALL have parameter ZFINX, default 0: 1 suppresses the FP bank even when FPU=1.
REQ-005 SHALL have parameter NUM_RD, default 3: number of read ports, range 1..4.
REQ-006 SHALL have parameter BYPASS, default 1: 1 forwards same-cycle write data to reads.
REQ-007 SHALL have parameter MAX_PENDING, default 4: maximum outstanding reservations, range 1..31.
REQ-008 SHALL have one clock `clk`; reset is asynchronous and active-low (`rst_n`).
REQ-009 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- raddr_i, in, NUM_RD x ADDR_WIDTH: read addresses.
- rdata_o, out, NUM_RD x DATA_WIDTH: read data, combinational.
- rbusy_o, out, NUM_RD: the addressed register awaits a pending write.
- waddr_a_i / wdata_a_i / we_a_i, in, ADDR_WIDTH / DATA_WIDTH / 1: write port A, short-latency.
- waddr_b_i / wdata_b_i / we_b_i, in, ADDR_WIDTH / DATA_WIDTH / 1: write port B, long-latency writeback.
- rsv_valid_i / rsv_addr_i, in, 1 / ADDR_WIDTH: destination reservation request.
- rsv_ready_o, out, 1: reservation can be accepted this cycle.
- flush_i, in, 1: drop all reservations.
- pend_cnt_o, out, $clog2(MAX_PENDING+1): outstanding reservation count.

Function
REQ-010 Integer x0 SHALL always read 0; writes and reservations to x0 SHALL be accepted with no effect.
REQ-011 With no FP bank, reads with MSB=1 SHALL return 0; writes and reservations to that bank SHALL be accepted with no effect.
REQ-012 Writes SHALL take effect at the clock edge; on the same address, port B SHALL win over port A.
REQ-013 BYPASS=1: a read of an address written this cycle SHALL return wdata_b_i if B writes it, else wdata_a_i. BYPASS=0: a read SHALL return stored contents (1-cycle write-to-read latency).
REQ-014 Scoreboard: one pending bit per valid non-x0 register.
REQ-015 rsv_ready_o SHALL equal !pending[rsv_addr_i] && pend_cnt_o < MAX_PENDING && !flush_i. A null target (x0 or absent bank) SHALL bypass only the count check.
REQ-016 An accepted reservation (rsv_valid_i && rsv_ready_o, non-null target) SHALL set the pending bit and increment the count at the next edge.
REQ-017 Any write SHALL clear the pending bit of its address at the edge. The count SHALL decrement once per distinct pending address cleared: 0, 1 or 2 per cycle.
REQ-018 Reserve and clear in the same cycle SHALL net the count: +1 -1 = unchanged. A write to a non-pending address SHALL leave the count unchanged.
REQ-019 rbusy_o[k] SHALL equal pending[raddr_i[k]], except it SHALL be 0 when BYPASS=1 and the address is written this cycle.
REQ-020 flush_i SHALL clear all pending bits and the count at the next edge, overriding same-cycle reserves and clears; register contents SHALL be unaffected.
REQ-021 The count SHALL never exceed MAX_PENDING nor underflow. A count/pending-bit mismatch SHALL fire a simulation assertion.

Reset
REQ-022 On rst_n low, all registers, pending bits and pend_cnt_o SHALL go to 0 immediately. rdata_o SHALL read 0, rbusy_o 0, and rsv_ready_o 1 unless flush_i is high.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight reservations; no writes SHALL be lost after rst_n deasserts.

Structure
REQ-024 rv32imf_pkg SHALL hold the bank-select bit position, REG_ZERO index and the pending-count width function.
REQ-025 The scoreboard (pending bits, counter, ready logic) SHALL be the sub-module rv32imf_regfile_scoreboard; storage and bypass SHALL stay in the top module.

Verification
REQ-026 Reset, then read all 64 addresses (FPU=1, ZFINX=0) -> all 0; rsv_ready_o=1; pend_cnt_o=0.
REQ-027 Same-cycle A write x5=0x11 and B write x5=0x22, raddr x5 -> BYPASS=1 reads 0x22 that cycle; BYPASS=0 reads 0x22 the next cycle.
REQ-028 Reserve x3, x4, x7, x9 (MAX_PENDING=4), then request x10 -> rsv_ready_o=0. Then B writes x4 -> count 3, and x10 is accepted the following cycle.
REQ-029 Reserve x6 and B write x6 in the same cycle with x6 not pending -> x6 pending, count +1. Re-request x6 -> rsv_ready_o=0.
REQ-030 A writes x3 and B writes x7 while both are pending -> count decreases by 2 and rbusy_o for both is 0 at the next edge.
REQ-031 With 3 pending, assert flush_i with rsv_valid_i on x8 -> count 0, no pending bits, and x8 not reserved. Also check x0 reservation/write -> x0 stays 0 and count unchanged.
